// File: rtl/meter_pkg.sv
// Shared types and default constants for the parking meter countdown path.
// State encoding matches the 2-bit state output seen by the display logic.
package meter_pkg;

  localparam int unsigned SEC_W = 12;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LOW   = 2'b01,
    ST_RUN   = 2'b10
  } meter_state_t;

  localparam int unsigned DEF_ADD_A      = 60;
  localparam int unsigned DEF_ADD_B      = 120;
  localparam int unsigned DEF_ADD_C      = 180;
  localparam int unsigned DEF_ADD_D      = 300;
  localparam int unsigned DEF_SET_LO     = 10;
  localparam int unsigned DEF_SET_HI     = 205;
  localparam int unsigned DEF_LOW_THRESH = 180;
  localparam int unsigned DEF_MAX_SEC    = 3599;

  function automatic meter_state_t decode_state(input logic [SEC_W-1:0] sec,
                                                input logic [SEC_W-1:0] low_thresh);
    if (sec == '0)            return ST_EMPTY;
    else if (sec < low_thresh) return ST_LOW;
    else                       return ST_RUN;
  endfunction

endpackage

// File: rtl/meter_blink.sv
// Blink gate for the display: steady in RUN, 2 Hz toggle in LOW, 1 Hz toggle in EMPTY.
// One-cycle registered latency; a state change forces the display on and restarts the phase.
module meter_blink
  import meter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  meter_state_t state,
  input  logic         state_chg,
  input  logic         tick_1hz,
  input  logic         tick_2hz,
  output logic         display_on
);

  logic phase;

  // display_on always equals !phase; the phase reg keeps the toggle history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      display_on <= 1'b1;
    end else if (state_chg) begin
      phase      <= 1'b0;
      display_on <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          phase      <= 1'b0;
          display_on <= 1'b1;
        end
        ST_LOW: begin
          if (tick_2hz) begin
            phase      <= ~phase;
            display_on <= phase;
          end
        end
        default: begin
          if (tick_1hz) begin
            phase      <= ~phase;
            display_on <= phase;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/meter_countdown_ctrl.sv
// Remaining-time register for the meter: loads credit, counts down at 1 Hz, saturates at MAX_SEC.
// All outputs registered (1-cycle latency); no backpressure, every pulse is consumed on its cycle.
module meter_countdown_ctrl
  import meter_pkg::*;
#(
  parameter int unsigned ADD_A      = DEF_ADD_A,
  parameter int unsigned ADD_B      = DEF_ADD_B,
  parameter int unsigned ADD_C      = DEF_ADD_C,
  parameter int unsigned ADD_D      = DEF_ADD_D,
  parameter int unsigned SET_LO     = DEF_SET_LO,
  parameter int unsigned SET_HI     = DEF_SET_HI,
  parameter int unsigned LOW_THRESH = DEF_LOW_THRESH,
  parameter int unsigned MAX_SEC    = DEF_MAX_SEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             add_a,
  input  logic             add_b,
  input  logic             add_c,
  input  logic             add_d,
  input  logic             set_lo,
  input  logic             set_hi,
  output logic [SEC_W-1:0] sec_count,
  output logic [1:0]       state,
  output logic             expired,
  output logic             display_on
);

  localparam int unsigned CALC_W = 14;

  meter_state_t     state_q;
  meter_state_t     next_state;
  logic [SEC_W-1:0] next_sec;
  logic [CALC_W-1:0] add_sum;
  logic [CALC_W-1:0] raw_sum;
  logic             dec;
  logic             state_chg;

  assign dec = tick_1hz && (sec_count != '0);

  // Worst case is MAX_SEC plus all four credits, so the sum needs headroom past 12 bits.
  always_comb begin
    add_sum = '0;
    if (add_a) add_sum = add_sum + CALC_W'(ADD_A);
    if (add_b) add_sum = add_sum + CALC_W'(ADD_B);
    if (add_c) add_sum = add_sum + CALC_W'(ADD_C);
    if (add_d) add_sum = add_sum + CALC_W'(ADD_D);
    raw_sum = {2'b00, sec_count} - CALC_W'(dec) + add_sum;
  end

  always_comb begin
    next_sec = sec_count;
    if (set_hi) begin
      next_sec = SEC_W'(SET_HI);
    end else if (set_lo) begin
      next_sec = SEC_W'(SET_LO);
    end else if (raw_sum > CALC_W'(MAX_SEC)) begin
      next_sec = SEC_W'(MAX_SEC);
    end else begin
      next_sec = raw_sum[SEC_W-1:0];
    end
  end

  assign next_state = decode_state(next_sec, SEC_W'(LOW_THRESH));
  assign state_chg  = (next_state != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count <= '0;
      state_q   <= ST_EMPTY;
      expired   <= 1'b1;
    end else begin
      sec_count <= next_sec;
      state_q   <= next_state;
      expired   <= (next_state == ST_EMPTY);
    end
  end

  assign state = state_q;

  meter_blink u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (next_state),
    .state_chg  (state_chg),
    .tick_1hz   (tick_1hz),
    .tick_2hz   (tick_2hz),
    .display_on (display_on)
  );

endmodule

// File: tb/tb_meter_countdown_ctrl.sv
// Directed bench for meter_countdown_ctrl: credit, countdown, saturation, priority, blink and async reset.
module tb_meter_countdown_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick_1hz, tick_2hz;
  logic        add_a, add_b, add_c, add_d;
  logic        set_lo, set_hi;
  logic [11:0] sec_count;
  logic [1:0]  state;
  logic        expired;
  logic        display_on;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] T1 = 8'h80;
  localparam logic [7:0] T2 = 8'h40;
  localparam logic [7:0] A  = 8'h20;
  localparam logic [7:0] B  = 8'h10;
  localparam logic [7:0] C  = 8'h08;
  localparam logic [7:0] D  = 8'h04;
  localparam logic [7:0] LO = 8'h02;
  localparam logic [7:0] HI = 8'h01;

  meter_countdown_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .tick_2hz   (tick_2hz),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_c      (add_c),
    .add_d      (add_d),
    .set_lo     (set_lo),
    .set_hi     (set_hi),
    .sec_count  (sec_count),
    .state      (state),
    .expired    (expired),
    .display_on (display_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int sec, input int st, input int exp_v,
                            input int disp);
    chk({tag, ".sec"},  16'(sec_count),  16'(sec));
    chk({tag, ".st"},   16'(state),      16'(st));
    chk({tag, ".exp"},  16'(expired),    16'(exp_v));
    chk({tag, ".disp"}, 16'(display_on), 16'(disp));
  endtask

  // Drive one cycle of pulses just after an edge, sample 1 time unit past the next edge.
  task automatic drive(input logic [7:0] v);
    {tick_1hz, tick_2hz, add_a, add_b, add_c, add_d, set_lo, set_hi} = v;
    @(posedge clk);
    #1;
    {tick_1hz, tick_2hz, add_a, add_b, add_c, add_d, set_lo, set_hi} = 8'h00;
  endtask

  task automatic drive_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  initial begin
    rst_n = 1'b0;
    {tick_1hz, tick_2hz, add_a, add_b, add_c, add_d, set_lo, set_hi} = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 1, 1);
    rst_n = 1'b1;

    drive(A);            expect_out("add_a",    60, 1, 0, 1);
    drive(T2);           expect_out("low_blk1", 60, 1, 0, 0);
    drive(T1 | T2);      expect_out("low_blk2", 59, 1, 0, 1);

    drive(HI);           expect_out("set_hi",   205, 2, 0, 1);
    drive_n(T1 | T2, 25); expect_out("run_180", 180, 2, 0, 1);
    drive(T1 | T2);      expect_out("enter_low", 179, 1, 0, 1);
    drive(T2);           expect_out("low_blk3", 179, 1, 0, 0);

    drive(HI);
    drive_n(T1, 5);
    drive_n(D, 11);      expect_out("at_3500",  3500, 2, 0, 1);
    drive(D);            expect_out("sat_d",    3599, 2, 0, 1);
    drive(A);            expect_out("sat_a",    3599, 2, 0, 1);
    drive(T1 | A);       expect_out("sat_tick", 3599, 2, 0, 1);

    drive(LO);           expect_out("set_lo",   10, 1, 0, 1);
    drive(LO | HI | D | T1); expect_out("prio", 205, 2, 0, 1);

    drive(LO);
    drive_n(T1, 9);      expect_out("at_1",     1, 1, 0, 1);
    drive(T1);           expect_out("expire",   0, 0, 1, 1);
    drive(T2);           expect_out("empty_t2", 0, 0, 1, 1);
    drive(T1 | T2);      expect_out("empty_t1a", 0, 0, 1, 0);
    drive(T1);           expect_out("empty_t1b", 0, 0, 1, 1);

    drive(A | B | C | D); expect_out("all_adds", 660, 2, 0, 1);

    drive(LO);
    drive(B);
    drive_n(T1, 30);     expect_out("at_100",   100, 1, 0, 1);
    drive(T1 | A);       expect_out("tick_add", 159, 1, 0, 1);

    drive(LO);
    drive(D);
    drive(A);
    drive(A);
    drive_n(T1, 30);     expect_out("at_400",   400, 2, 0, 1);

    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 1, 1);
    @(posedge clk);
    #1;
    expect_out("rst_hold", 0, 0, 1, 1);
    rst_n = 1'b1;
    drive(T2);           expect_out("post_t2",  0, 0, 1, 1);
    drive(T1);           expect_out("post_t1",  0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
